// File: rtl/fb_write_arbiter_if.sv
// Requester and framebuffer write-port bundle for fb_write_arbiter.
// master = arbiter side, slave = renderers/framebuffer side.
interface fb_write_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 19,
  parameter int unsigned DW    = 16
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [AW-1:0]       dst_addr;
  logic [DW-1:0]       dst_data;
  logic                dst_wr;
  logic                dst_ready;

  modport master (
    input  req_valid, req_addr, req_data, dst_ready,
    output req_ready, dst_addr, dst_data, dst_wr
  );

  modport slave (
    output req_valid, req_addr, req_data, dst_ready,
    input  req_ready, dst_addr, dst_data, dst_wr
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one registered framebuffer write port.
// Define FB_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module fb_write_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned AW        = 19,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                clk,
  input  logic                rstn,
  fb_write_arbiter_if.master  bus,
  output logic [1:0]          owner,
  output logic                busy
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_owner;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_dst_addr;
  logic [DW-1:0]    r_dst_data;
  logic             r_dst_wr;

  logic [1:0]       w_base;
  logic             w_hit;
  logic [1:0]       w_hit_idx;
  logic             w_owner_valid;
  logic [AW-1:0]    w_owner_addr;
  logic [DW-1:0]    w_owner_data;
  logic             w_slot_free;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_accept;
  logic             w_release;

`ifdef FB_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [1:0] r_rr_ptr;
  logic [1:0] w_owner_inc;

  assign w_base      = r_rr_ptr;
  assign w_owner_inc = (32'(r_owner) + 32'd1 >= N_REQ) ? '0 : r_owner + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (r_state == GRANT && w_release) begin
      r_rr_ptr <= w_owner_inc;
    end
  end
`endif

  // Wrapped search: indices >= base first, then the ones below base.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_hit && bus.req_valid[i] && (i >= 32'(w_base))) begin
        w_hit     = 1'b1;
        w_hit_idx = i[1:0];
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_hit && bus.req_valid[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = i[1:0];
      end
    end
  end

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_addr  = '0;
    w_owner_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(r_owner) == i) begin
        w_owner_valid = bus.req_valid[i];
        w_owner_addr  = bus.req_addr[i*AW +: AW];
        w_owner_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_slot_free = ~r_dst_wr | bus.dst_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) w_state_nxt = GRANT;
      end
      GRANT: begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (32'(r_owner) == i) w_req_ready[i] = w_slot_free;
        end
        w_accept  = w_owner_valid & w_slot_free;
        w_release = ~w_owner_valid | (w_accept & (r_cnt >= CW'(MAX_BURST - 1)));
        if (w_release) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_hit) begin
        r_owner <= w_hit_idx;
        r_cnt   <= '0;
      end
    end else if (w_accept && r_cnt < CW'(MAX_BURST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A stalled write is never overwritten: accept requires a free slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dst_addr <= '0;
      r_dst_data <= '0;
      r_dst_wr   <= 1'b0;
    end else if (w_accept) begin
      r_dst_addr <= w_owner_addr;
      r_dst_data <= w_owner_data;
      r_dst_wr   <= 1'b1;
    end else if (bus.dst_ready) begin
      r_dst_wr   <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.dst_addr  = r_dst_addr;
  assign bus.dst_data  = r_dst_data;
  assign bus.dst_wr    = r_dst_wr;
  assign owner         = r_owner;
  assign busy          = (r_state == GRANT);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: accepted writes are queued and matched
// against the framebuffer port; grant order, bubbles and stalls checked per scenario.
module tb_fb_write_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;
`ifdef FB_ARB_FIXED_PRIO_EN
  localparam int unsigned MB_SMALL = 2;
`else
  localparam int unsigned MB_SMALL = 4;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    drv_valid  = '0;
  logic [N*AW-1:0] drv_addr   = '0;
  logic [N*DW-1:0] drv_data   = '0;
  logic            drv_dready = 1'b1;
  logic            sel_b      = 1'b0;

  fb_write_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus_a ();
  fb_write_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus_b ();

  assign bus_a.req_valid = drv_valid;
  assign bus_a.req_addr  = drv_addr;
  assign bus_a.req_data  = drv_data;
  assign bus_a.dst_ready = drv_dready;
  assign bus_b.req_valid = drv_valid;
  assign bus_b.req_addr  = drv_addr;
  assign bus_b.req_data  = drv_data;
  assign bus_b.dst_ready = drv_dready;

  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b;

  fb_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_BURST(64)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .owner(owner_a), .busy(busy_a)
  );
  fb_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB_SMALL)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .owner(owner_b), .busy(busy_b)
  );

  logic [N-1:0]  o_ready;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_wr;
  logic [1:0]    o_owner;
  logic          o_busy;

  always_comb begin
    o_ready = sel_b ? bus_b.req_ready : bus_a.req_ready;
    o_addr  = sel_b ? bus_b.dst_addr  : bus_a.dst_addr;
    o_data  = sel_b ? bus_b.dst_data  : bus_a.dst_data;
    o_wr    = sel_b ? bus_b.dst_wr    : bus_a.dst_wr;
    o_owner = sel_b ? owner_b         : owner_a;
    o_busy  = sel_b ? busy_b          : busy_a;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-requester write lists presented on valid/ready
  logic [AW-1:0] s_addr [N][64];
  logic [DW-1:0] s_data [N][64];
  int            s_len  [N];
  int            s_pos  [N];

  logic [AW+DW-1:0] sb [$];

  int cyc = 0;
  int valid_cyc, busy_cyc;
  int ng, wr_cnt, wr_run, wr_run_max, n_stall, idle_run;
  int glog [32];
  int gacc [32];
  int gap  [32];
  int st_from, st_len;
  bit busy_prev = 1'b0;
  bit stall_prev = 1'b0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;

  task automatic clear_stats();
    ng = 0; wr_cnt = 0; wr_run = 0; wr_run_max = 0; n_stall = 0; idle_run = 0;
    valid_cyc = -1; busy_cyc = -1; st_from = -100; st_len = 0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 0;
      s_pos[i] = 0;
    end
  endtask

  task automatic load_src(input int i, input int n, input int base, input int d0, input int dstep);
    for (int k = 0; k < n; k++) begin
      s_addr[i][k] = AW'(base + k);
      s_data[i][k] = DW'(d0 + k * dstep);
    end
    s_len[i] = n;
    s_pos[i] = 0;
  endtask

  task automatic drive();
    int nxt;
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = (s_pos[i] < s_len[i]);
      if (drv_valid[i]) begin
        drv_addr[i*AW +: AW] = s_addr[i][s_pos[i]];
        drv_data[i*DW +: DW] = s_data[i][s_pos[i]];
      end
    end
    nxt = cyc + 1;
    drv_dready = !(nxt >= st_from && nxt < st_from + st_len);
  endtask

  function automatic bit all_done();
    bit d = 1'b1;
    for (int i = 0; i < N; i++) if (s_pos[i] < s_len[i]) d = 1'b0;
    return d;
  endfunction

  task automatic step();
    logic [N-1:0]     acc;
    logic [AW+DW-1:0] exp;
    @(negedge clk);
    cyc++;
    if (valid_cyc < 0 && drv_valid != '0) valid_cyc = cyc;
    if (busy_cyc < 0 && o_busy) busy_cyc = cyc;
    if (stall_prev) begin
      check("stall_addr", o_addr, held_a);
      check("stall_data", o_data, held_d);
      check("stall_wr", o_wr, 1);
    end
    stall_prev = 1'b0;
    if (o_wr && !drv_dready) begin
      check("stall_ready", o_ready, 0);
      stall_prev = 1'b1;
      held_a = o_addr;
      held_d = o_data;
      n_stall++;
    end
    if (o_wr && drv_dready) begin
      wr_cnt++;
      wr_run++;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("wr_addr_data", {o_addr, o_data}, exp);
      end
    end else begin
      wr_run = 0;
    end
    if (wr_run > wr_run_max) wr_run_max = wr_run;
    if (o_busy && !busy_prev) begin
      if (ng > 0 && ng < 32) gap[ng] = idle_run;
      if (ng < 32) begin
        glog[ng] = int'(o_owner);
        gacc[ng] = 0;
      end
      ng++;
    end
    idle_run  = o_busy ? 0 : idle_run + 1;
    busy_prev = o_busy;
    acc = drv_valid & o_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        check("acc_owner", o_owner, i);
        sb.push_back({s_addr[i][s_pos[i]], s_data[i][s_pos[i]]});
        if (ng > 0 && ng <= 32) gacc[ng-1]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) s_pos[i]++;
    drive();
  endtask

  task automatic run_drain(input int maxc);
    int k = 0;
    drive();
    do begin
      step();
      k++;
    end while (k < maxc && !(all_done() && !o_busy && !o_wr && sb.size() == 0));
    check("drain_in_time", k < maxc, 1);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    clear_sources();
    sb.delete();
    stall_prev = 1'b0;
    busy_prev  = 1'b0;
    clear_stats();
    drive();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_sources();
    clear_stats();
    reset_dut();
    #1;
    check("rst_dst_wr", o_wr, 0);
    check("rst_dst_addr", o_addr, 0);
    check("rst_dst_data", o_data, 0);
    check("rst_req_ready", o_ready, 0);
    check("rst_owner", o_owner, 0);
    check("rst_busy", o_busy, 0);

    // Single requester 2, five writes
    load_src(2, 5, 100, 'hF800, 0);
    run_drain(100);
    check("t1_wr_count", wr_cnt, 5);
    check("t1_wr_run", wr_run_max, 5);
    check("t1_busy_latency", busy_cyc - valid_cyc, 1);
    check("t1_grants", ng, 1);
    check("t1_owner", glog[0], 2);

    // Backpressure: three stalled cycles mid-burst
    clear_stats();
    load_src(0, 6, 200, 'h07E0, 1);
    st_from = cyc + 4;
    st_len  = 3;
    run_drain(100);
    check("t3_wr_count", wr_cnt, 6);
    check("t3_stall_cycles", n_stall, 3);
    check("t3_grants", ng, 1);

`ifndef FB_ARB_FIXED_PRIO_EN
    // Early release of req 1 while 0 and 2 wait (pointer sits at 1)
    clear_stats();
    load_src(0, 4, 300, 'h1111, 1);
    load_src(1, 2, 400, 'h2222, 1);
    load_src(2, 3, 500, 'h3333, 1);
    run_drain(200);
    check("t4a_grants", ng, 3);
    check("t4a_g0", glog[0], 1);
    check("t4a_g1", glog[1], 2);
    check("t4a_g2", glog[2], 0);
    check("t4a_wr_count", wr_cnt, 9);

    clear_stats();
    load_src(0, 3, 600, 'h4444, 1);
    load_src(1, 2, 700, 'h5555, 1);
    run_drain(200);
    check("t4b_grants", ng, 2);
    check("t4b_g0", glog[0], 1);
    check("t4b_g1", glog[1], 0);
`endif

    // Asynchronous reset in the middle of a burst
    clear_stats();
    load_src(0, 20, 800, 'h0F0F, 1);
    drive();
    repeat (5) step();
    check("t5_pre_busy", o_busy, 1);
    check("t5_pre_wr", o_wr, 1);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_wr", o_wr, 0);
    check("t5_rst_ready", o_ready, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_addr", o_addr, 0);
    clear_sources();
    sb.delete();
    stall_prev = 1'b0;
    busy_prev  = 1'b0;
    drive();
    @(posedge clk);
    #1 rstn = 1'b1;
    clear_stats();
    load_src(1, 2, 900, 'hAAAA, 1);
    load_src(2, 2, 950, 'hBBBB, 1);
    run_drain(100);
    check("t5_first_owner", glog[0], 1);
    check("t5_second_owner", glog[1], 2);
    check("t5_wr_count", wr_cnt, 4);

    sel_b = 1'b1;
    reset_dut();
`ifndef FB_ARB_FIXED_PRIO_EN
    // Round-robin with MAX_BURST = 4, all requesters saturated
    for (int i = 0; i < N; i++) load_src(i, 12, 1000 * (i + 1), 'h100 * (i + 1), 1);
    run_drain(400);
    check("rr_grants", ng, 9);
    for (int g = 0; g < 9; g++) begin
      check("rr_owner", glog[g], g % 3);
      check("rr_burst", gacc[g], 4);
      if (g > 0) check("rr_bubble", gap[g], 1);
    end
    check("rr_wr_count", wr_cnt, 36);
`else
    // Fixed priority with MAX_BURST = 2: req 0 keeps winning
    load_src(0, 8, 1000, 'h0100, 1);
    load_src(2, 4, 3000, 'h0300, 1);
    run_drain(300);
    check("fp_grants", ng, 6);
    for (int g = 0; g < 6; g++) begin
      check("fp_owner", glog[g], (g < 4) ? 0 : 2);
      check("fp_burst", gacc[g], 2);
    end
    check("fp_wr_count", wr_cnt, 12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port (19-bit address, 16-bit RGB565 data, write strobe) between several renderers: the map/tile renderer, the sprite renderer and the HUD number renderer. Each renderer presents writes on a valid/ready port. The arbiter grants one requester at a time in round-robin order, holds the grant for a bounded burst, and drives one registered write per cycle into the framebuffer. It sits between the renderers and the framebuffer RAM/VGA-contention logic.

## Interface
- `N_REQ`, 3, number of requesters; index 0 = map, 1 = sprite, 2 = HUD.
- `AW`, 19, address width.
- `DW`, 16, data width.
- `MAX_BURST`, 64, maximum accepted writes per grant (≥1).
- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i has a write pending.
- `req_addr` in N_REQ*AW: requester i address at bits [i*AW +: AW].
- `req_data` in N_REQ*DW: requester i data at bits [i*DW +: DW].
- `req_ready` out N_REQ: one-hot or zero; the write from requester i is accepted when `req_valid[i] & req_ready[i]`.
- `dst_addr` out AW: registered framebuffer address.
- `dst_data` out DW: registered framebuffer data.
- `dst_wr` out 1: registered write strobe.
- `dst_ready` in 1: the framebuffer takes the write this cycle; tie high for plain BRAM.
- `owner` out 2: index of the current grant holder; valid while `busy`.
- `busy` out 1: high in GRANT.

## Operation
- FSM with two states: IDLE and GRANT.
- **IDLE:**
  - Search `req_valid` starting at index `rr_ptr`, wrapping modulo N_REQ.
  - On the first hit: `owner` ← index, burst count ← 0, go to GRANT.
  - With no hit: stay in IDLE.
  - `req_ready` = 0 in IDLE.
- **GRANT:**
  - `req_ready[owner] = ~dst_wr | dst_ready`; all other bits of `req_ready` are 0.
  - On accept: output register ← (addr, data) of the owner, `dst_wr` ← 1, burst count += 1.
  - When there is no accept and `dst_ready` = 1, `dst_wr` ← 0.
- **Output register:**
  - Holds its contents and keeps `dst_wr` high while `dst_wr & ~dst_ready`.
  - It is never overwritten while stalled.
- **Release (GRANT → IDLE), whichever comes first:**
  - `req_valid[owner]` = 0 in a GRANT cycle.
  - The accept that brings the burst count to MAX_BURST.
  - On release, `rr_ptr` ← (owner + 1) mod N_REQ.
- **Pending write across release:** a write still in the output register completes normally after release. IDLE does not touch the output register.
- **Handshake rule on requesters:** addr/data are sampled only on accept. A requester may drop valid at any time; the arbiter treats that as release.
- **Burst counter:** width clog2(MAX_BURST)+1 bits; it saturates, never wraps.
- **Out-of-range index:** when N_REQ is not a power of two, indices ≥ N_REQ are never granted.

## Timing
- **Reset values:**
  - `dst_wr` = 0, `dst_addr` = 0, `dst_data` = 0.
  - `req_ready` = 0, `owner` = 0, `busy` = 0.
  - `rr_ptr` = 0, state = IDLE.
- **Arbitration:** 1 cycle. A request seen in IDLE at cycle t gives `busy` = 1 and `req_ready` at cycle t+1.
- **Write latency:** an accept at edge t gives `dst_wr`, `dst_addr` and `dst_data` valid after edge t (one register stage).
- **Throughput:** 1 write/cycle inside a burst while `dst_ready` = 1. There is exactly one idle bubble cycle on each owner change.
- **Simultaneous requests:** resolved by `rr_ptr` order. A newly asserted `req_valid` never preempts an active grant.
- **Mid-operation reset:** an asynchronous reset mid-burst clears all state immediately. The in-flight write is dropped with no partial strobe.

## Configuration
- `FB_ARB_FIXED_PRIO_EN`:
  - Defined: the IDLE search always starts at index 0, giving fixed priority map > sprite > HUD. `rr_ptr` is not updated. MAX_BURST still bounds each grant.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single requester:** after reset, only req 2 is valid with 5 writes (addr 100..104, data 0xF800), `dst_ready` = 1 → `busy` rises 1 cycle later. `dst_wr` is high for exactly 5 consecutive cycles with addresses 100..104, then `busy` falls.
- **Round-robin:** all 3 requesters continuously valid, MAX_BURST = 4 → grant sequence is 0,1,2,0,…. Each grant carries 4 writes, with 1 bubble between grants.
- **Backpressure:** `dst_ready` is held low for 3 cycles mid-burst → `dst_addr`/`dst_data` stay stable and `dst_wr` stays high. `req_ready[owner]` = 0 during the stall. No write is lost or duplicated; the count matches the accepted writes.
- **Early release:** req 1 drops valid after 2 writes while req 0 is valid → one bubble, then owner = 2 if req 2 is valid, else 0. `rr_ptr` becomes 2.
- **Reset mid-burst:** `rstn` is asserted low in the middle of a grant → `dst_wr`, `req_ready` and `busy` go to 0 immediately. After release, the first grant goes to the lowest valid index.
- **`FB_ARB_FIXED_PRIO_EN` defined:** reqs 0 and 2 are continuously valid, MAX_BURST = 2 → req 0 is re-granted after every release and req 2 gets no grant while req 0 stays valid.
